// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a small combinational gate.
// Sweeps all input vectors, compares against a latched truth table.
module gate_bist_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected_tt,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic                 pass,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int NV = 2**N_IN;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST =
    SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN:0]   FC_MAX   = (N_IN+1)'(NV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // With no settle time each vector goes straight to its compare.
  localparam logic [1:0] S_VEC = (SETTLE == 0) ? S_CHECK : S_HOLD;

  logic [1:0]        r_state;
  logic [NV-1:0]     r_tt;
  logic [N_IN-1:0]   r_dut_in;
  logic [SW-1:0]     r_settle;
  logic              r_busy;
  logic              r_done;
  logic              r_rv;
  logic              r_pass;
  logic [N_IN:0]     r_fail_cnt;
  logic [N_IN-1:0]   r_ff_vec;
  logic              r_ff_valid;

  logic              w_exp;
  logic              w_miss;
  logic              w_last;
  logic [N_IN:0]     w_fail_nxt;

  assign w_exp  = r_tt[r_dut_in];
  assign w_last = (r_dut_in == VEC_LAST);

  // An unknown gate output must fall into the mismatch branch.
  always_comb begin
    w_miss = 1'b1;
    if (dut_out == w_exp) w_miss = 1'b0;
  end

  always_comb begin
    w_fail_nxt = r_fail_cnt;
    if (w_miss && (r_fail_cnt != FC_MAX))
      w_fail_nxt = r_fail_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tt       <= '0;
      r_dut_in   <= '0;
      r_settle   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rv       <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_cnt <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_dut_in <= '0;
        r_settle <= '0;
        r_rv     <= 1'b0;
        r_pass   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_tt       <= expected_tt;
              r_state    <= S_VEC;
              r_dut_in   <= '0;
              r_settle   <= '0;
              r_busy     <= 1'b1;
              r_fail_cnt <= '0;
              r_ff_vec   <= '0;
              r_ff_valid <= 1'b0;
              r_rv       <= 1'b0;
              r_pass     <= 1'b0;
            end
          end
          S_HOLD: begin
            if (r_settle == SET_LAST) begin
              r_settle <= '0;
              r_state  <= S_CHECK;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          S_CHECK: begin
            r_fail_cnt <= w_fail_nxt;
            if (w_miss && !r_ff_valid) begin
              r_ff_vec   <= r_dut_in;
              r_ff_valid <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_rv    <= 1'b1;
              r_pass  <= (w_fail_nxt == '0);
            end else begin
              r_dut_in <= r_dut_in + 1'b1;
              r_state  <= S_VEC;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dut_in           = r_dut_in;
  assign busy             = r_busy;
  assign done             = r_done;
  assign result_valid     = r_rv;
  assign pass             = r_pass;
  assign fail_count       = r_fail_cnt;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: SETTLE=1 and SETTLE=3 builds
// driven from shared stimulus, each with its own gate model.
module tb_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] expected_tt;
  logic [1:0] mode;

  logic [2:0] dut_in, dut_in3;
  logic       dut_out, dut_out3;
  logic       busy, done, rv, pass, ffval;
  logic       busy3, done3, rv3, pass3, ffval3;
  logic [3:0] fc, fc3;
  logic [2:0] ffv, ffv3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // mode 0: healthy AND, 1: stuck-at-0, 2: stuck-at-1
  assign dut_out  = (mode == 2'd0) ? &dut_in :
                    (mode == 2'd1) ? 1'b0 : 1'b1;
  assign dut_out3 = &dut_in3;

  gate_bist_ctrl #(.N_IN(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .expected_tt(expected_tt), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .result_valid(rv), .pass(pass),
    .fail_count(fc), .first_fail_vec(ffv), .first_fail_valid(ffval)
  );

  gate_bist_ctrl #(.N_IN(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .expected_tt(expected_tt), .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .result_valid(rv3), .pass(pass3),
    .fail_count(fc3), .first_fail_vec(ffv3), .first_fail_valid(ffval3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse sampled at edge 0, then 36 further edges observed.
  task automatic run(input logic [7:0] tt, input logic [1:0] md,
                     input int abort_e, input bit rep, input bit tchg,
                     input bit traj, output int done_e,
                     output int done_cnt, output int done3_e);
    int exp_v;
    mode        = md;
    expected_tt = tt;
    start       = 1'b1;
    tick();
    start    = 1'b0;
    done_e   = -1;
    done3_e  = -1;
    done_cnt = 0;
    for (int e = 1; e <= 36; e++) begin
      start = rep && (e == 3 || e == 9);
      abort = (e == abort_e);
      if (tchg && e == 5) expected_tt = ~tt;
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_e < 0) done_e = e;
      end
      if (done3 && done3_e < 0) done3_e = e;
      if (traj && e <= 16) begin
        exp_v = (e >= 16) ? 7 : e / 2;
        checks++;
        if (int'(dut_in) !== exp_v) begin
          failures++;
          $display("FAIL traj_e%0d dut_in=%0d want=%0d", e, dut_in, exp_v);
        end
      end
      if (traj && e <= 32 && (e % 4 == 3 || e % 4 == 0)) begin
        exp_v = (e >= 32) ? 7 : e / 4;
        checks++;
        if (int'(dut_in3) !== exp_v) begin
          failures++;
          $display("FAIL traj3_e%0d dut_in=%0d want=%0d", e, dut_in3, exp_v);
        end
      end
      if (abort_e > 0 && e == abort_e - 1) begin
        checks++;
        if ({busy, dut_in} !== 4'b1_011) begin
          failures++;
          $display("FAIL pre_abort busy/dut_in=%b want=1011", {busy, dut_in});
        end
      end
      if (abort_e > 0 && e == abort_e) begin
        checks++;
        if ({busy, dut_in, rv, pass} !== 6'b0) begin
          failures++;
          $display("FAIL post_abort busy/dut_in/rv/pass=%b want=000000",
                   {busy, dut_in, rv, pass});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    expected_tt = 8'h80; mode = 2'd0;
    #3;
    checks++;
    if ({dut_in, busy, done, rv, pass, fc, ffv, ffval} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {dut_in, busy, done, rv, pass, fc, ffv, ffval});
    end
    checks++;
    if ({dut_in3, busy3, done3, rv3, pass3, fc3, ffv3, ffval3} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs3 got=%h want=0",
               {dut_in3, busy3, done3, rv3, pass3, fc3, ffv3, ffval3});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_and_pass();
    int de, dc, de3;
    run(8'h80, 2'd0, -1, 1'b0, 1'b0, 1'b1, de, dc, de3);
    checks++;
    if (de !== 16 || dc !== 1) begin
      failures++;
      $display("FAIL and_done edge=%0d cnt=%0d want 16/1", de, dc);
    end
    checks++;
    if ({rv, pass, fc, ffval} !== 7'b11_0000_0) begin
      failures++;
      $display("FAIL and_result rv/pass/fc/ffval=%b want=1100000",
               {rv, pass, fc, ffval});
    end
    checks++;
    if (de3 !== 32 || pass3 !== 1'b1 || fc3 !== 4'd0) begin
      failures++;
      $display("FAIL settle3 done_edge=%0d pass=%b fc=%0d want 32/1/0",
               de3, pass3, fc3);
    end
  endtask

  task automatic test_stuck0();
    int de, dc, de3;
    run(8'h80, 2'd1, -1, 1'b0, 1'b0, 1'b0, de, dc, de3);
    checks++;
    if (fc !== 4'd1 || ffv !== 3'd7 || ffval !== 1'b1) begin
      failures++;
      $display("FAIL stuck0 fc=%0d ffv=%0d ffval=%b want 1/7/1", fc, ffv, ffval);
    end
    checks++;
    if (pass !== 1'b0 || rv !== 1'b1 || de !== 16) begin
      failures++;
      $display("FAIL stuck0_status pass=%b rv=%b edge=%0d want 0/1/16",
               pass, rv, de);
    end
  endtask

  task automatic test_stuck1();
    int de, dc, de3;
    run(8'h80, 2'd2, -1, 1'b0, 1'b0, 1'b0, de, dc, de3);
    checks++;
    if (fc !== 4'd7 || ffv !== 3'd0 || ffval !== 1'b1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck1 fc=%0d ffv=%0d ffval=%b pass=%b want 7/0/1/0",
               fc, ffv, ffval, pass);
    end
  endtask

  task automatic test_restart_ignored();
    int de, dc, de3;
    run(8'h80, 2'd0, -1, 1'b1, 1'b1, 1'b1, de, dc, de3);
    checks++;
    if (de !== 16 || dc !== 1) begin
      failures++;
      $display("FAIL restart_done edge=%0d cnt=%0d want 16/1", de, dc);
    end
    checks++;
    if (pass !== 1'b1 || fc !== 4'd0 || ffval !== 1'b0) begin
      failures++;
      $display("FAIL tt_latch pass=%b fc=%0d ffval=%b want 1/0/0",
               pass, fc, ffval);
    end
  endtask

  task automatic test_abort();
    int de, dc, de3;
    run(8'h80, 2'd0, 8, 1'b0, 1'b0, 1'b0, de, dc, de3);
    checks++;
    if (dc !== 0 || rv !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone cnt=%0d rv=%b busy=%b want 0/0/0",
               dc, rv, busy);
    end
    run(8'h80, 2'd0, -1, 1'b0, 1'b0, 1'b0, de, dc, de3);
    checks++;
    if (de !== 16 || pass !== 1'b1 || rv !== 1'b1) begin
      failures++;
      $display("FAIL after_abort edge=%0d pass=%b rv=%b want 16/1/1",
               de, pass, rv);
    end
  endtask

  task automatic test_reset_mid();
    int de, dc, de3;
    int seen = 0;
    mode = 2'd1;
    expected_tt = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dut_in, busy, done, rv, pass, fc, ffv, ffval} !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset got=%h want=0",
               {dut_in, busy, done, rv, pass, fc, ffv, ffval});
    end
    checks++;
    if ({dut_in3, busy3} !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset3 got=%h want=0", {dut_in3, busy3});
    end
    #2 rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mid_reset_quiet activity=%0d want=0", seen);
    end
    run(8'h80, 2'd0, -1, 1'b0, 1'b0, 1'b0, de, dc, de3);
    checks++;
    if (de !== 16 || pass !== 1'b1) begin
      failures++;
      $display("FAIL after_reset edge=%0d pass=%b want 16/1", de, pass);
    end
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_stuck0();
    test_stuck1();
    test_restart_ignored();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
Built-in self-test sequencer for a small combinational gate (default: 3-input AND). On start, it drives every input vector in ascending binary order onto the gate and samples the gate output after a programmable settle time. It compares each sample against a caller-supplied expected truth table and reports pass/fail, the mismatch count and the first failing vector. It sits between the gate instance and the test/status logic and replaces manual vector stepping.

Parameters:
N_IN, 3, number of gate inputs; the sweep covers 2**N_IN vectors.
SETTLE, 1, extra cycles each vector is held before sampling (>=0).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin sweep; honoured only in IDLE or DONE
abort  input  1  stop sweep; return to IDLE
expected_tt  input  2**N_IN  expected output; bit k = result for vector k
dut_in  output  N_IN  vector driven to gate inputs (bit 0 = LSB input)
dut_out  input  1  gate output
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when a sweep completes
result_valid  output  1  results valid; held until next start, abort or rst
pass  output  1  1 when result_valid and fail_count == 0
fail_count  output  N_IN+1  number of mismatching vectors
first_fail_vec  output  N_IN  lowest failing vector index
first_fail_valid  output  1  first_fail_vec holds a real failure

Behaviour:
- Reset (async, any state): state=IDLE. All outputs go to 0: dut_in, busy, done, result_valid, pass, fail_count, first_fail_vec, first_fail_valid. Internal vector and settle counters also clear.
- States: IDLE, HOLD, CHECK, DONE.
- IDLE/DONE + start (no abort):
  - expected_tt is latched; later changes are ignored.
  - Next cycle: state=HOLD, dut_in=0, busy=1.
  - fail_count, first_fail_*, result_valid and pass clear.
- HOLD: dut_in stays stable for SETTLE cycles, then the FSM goes to CHECK. With SETTLE=0, HOLD lasts 0 cycles (enter CHECK directly).
- CHECK (1 cycle):
  - dut_out is sampled at this edge and compared with latched_tt[dut_in].
  - On mismatch, fail_count increments. If first_fail_valid=0, first_fail_vec takes dut_in and first_fail_valid goes to 1.
  - If dut_in == 2**N_IN-1, go to DONE. Otherwise dut_in increments and the FSM returns to HOLD.
- Each vector occupies SETTLE+1 cycles. The last CHECK is at edge 2**N_IN*(SETTLE+1) after the start edge.
- DONE entry (same edge as last compare): busy=0, done=1 for one cycle, result_valid=1, pass=(final fail_count==0). dut_in holds its last value.
- fail_count never wraps; its width holds the maximum of 2**N_IN.
- start while busy: ignored, with no effect on counters.
- abort (any state, priority over start): next edge state=IDLE, busy=0, dut_in=0, result_valid=0, pass=0. done is not pulsed. Counters keep partial values but are invalid.
- start and abort in the same cycle: abort wins.
- rst mid-sweep: immediate return to reset values; no done pulse.
- Compare rules: X/Z on dut_out must not count as a match. Use case equality in the compare model; the RTL compares with ==.

Test Plan:
- Correct AND gate, expected_tt=8'b1000_0000, SETTLE=1, start pulsed at edge 0 -> dut_in steps 0..7, each held 2 cycles. done pulses at edge 16; pass=1, fail_count=0, first_fail_valid=0.
- Gate output stuck-at-0, same table -> fail_count=1, first_fail_vec=3'b111, pass=0, result_valid=1.
- Gate output stuck-at-1 -> fail_count=7, first_fail_vec=3'b000, pass=0.
- start re-pulsed at edges 3 and 9 during a sweep -> no restart; done still at edge 16. expected_tt changed mid-sweep -> results unchanged.
- abort at edge 7 -> busy=0 and dut_in=0 at edge 8; no done pulse; result_valid=0. A new start then completes normally.
- rst asserted mid-sweep (between edges) -> all outputs 0 immediately. SETTLE=3 build: done at edge 32, each dut_in value held 4 cycles.
